// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle 4-register CPU with Z/C flags, conditional
// branches, HALT and an output port. Instructions are fetched from an
// external memory that may insert wait states.
//
// Optional feature: define HW_MUL_EN to make opcode D an unsigned multiply
// (rd = low half of rd*rs). Without it opcode D is a NOP and no multiplier
// exists.
//
// Fetch handshake: instr_req is high for every cycle the core sits in FETCH;
// an instruction is taken on any rising edge where instr_req and instr_valid
// are both high (instr_valid may rise in the same cycle as instr_req).
// instr_addr is held stable for as long as instr_req stays high.
//
// Ports:
//   CLK          clock, rising edge
//   reset        synchronous, active-low
//   instr_req    fetch request (high in FETCH)
//   instr_addr   fetch address (= pc)
//   instr_valid  instr_data is valid this cycle
//   instr_data   16-bit instruction word {op[15:12], rd[11:10], rs[9:8], imm[7:0]}
//   ALUResult    result of the last ALU-class instruction
//   cpu_out      output port register
//   out_valid    one-cycle pulse after cpu_out is written
//   halted       high while in HALT
//   dbg_state    current FSM state (0 FETCH, 1 EXEC, 2 HALT)
//   dbg_flags    {Z, C}
module cpu_multicycle #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              CLK,
  input  logic              reset,
  output logic              instr_req,
  output logic [PC_W-1:0]   instr_addr,
  input  logic              instr_valid,
  input  logic [15:0]       instr_data,
  output logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] cpu_out,
  output logic              out_valid,
  output logic              halted,
  output logic [1:0]        dbg_state,
  output logic [1:0]        dbg_flags
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_MOV  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [15:0]        ir;
  logic [DATA_W-1:0]  rf [4];
  logic               z_flag;
  logic               c_flag;

  // Instruction fields
  logic [3:0]         op;
  logic [1:0]         rd;
  logic [1:0]         rs;
  logic [DATA_W-1:0]  imm_ext;
  logic [PC_W-1:0]    jmp_tgt;
  logic [DATA_W-1:0]  rd_val;
  logic [DATA_W-1:0]  rs_val;

  assign op      = ir[15:12];
  assign rd      = ir[11:10];
  assign rs      = ir[9:8];
  assign imm_ext = DATA_W'(ir[7:0]);
  assign jmp_tgt = PC_W'(ir[7:0]);
  assign rd_val  = rf[rd];
  assign rs_val  = rf[rs];

  assign instr_addr = pc;
  assign dbg_state  = state;
  assign dbg_flags  = {z_flag, c_flag};

  // ALU and next-pc, both from pre-edge register values
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_we;
  logic [DATA_W:0]     sum;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     pc_next;
`ifdef HW_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  assign pc_inc = pc + PC_W'(1);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_we  = 1'b0;
    sum     = '0;
`ifdef HW_MUL_EN
    prod    = '0;
`endif
    case (op)
      OP_ADD: begin
        sum     = {1'b0, rd_val} + {1'b0, rs_val};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_we  = 1'b1;
      end
      OP_SUB: begin
        alu_res = rd_val - rs_val;
        alu_c   = (rd_val < rs_val);
        alu_we  = 1'b1;
      end
      OP_AND: begin
        alu_res = rd_val & rs_val;
        alu_we  = 1'b1;
      end
      OP_OR: begin
        alu_res = rd_val | rs_val;
        alu_we  = 1'b1;
      end
      OP_XOR: begin
        alu_res = rd_val ^ rs_val;
        alu_we  = 1'b1;
      end
      OP_SHL: begin
        alu_res = {rd_val[DATA_W-2:0], 1'b0};
        alu_c   = rd_val[DATA_W-1];
        alu_we  = 1'b1;
      end
`ifdef HW_MUL_EN
      OP_MUL: begin
        prod    = {{DATA_W{1'b0}}, rd_val} * {{DATA_W{1'b0}}, rs_val};
        alu_res = prod[DATA_W-1:0];
        alu_c   = |prod[2*DATA_W-1:DATA_W];
        alu_we  = 1'b1;
      end
`endif
      default: begin
        alu_res = '0;
      end
    endcase
  end

  always_comb begin
    pc_next = pc_inc;
    case (op)
      OP_JMP:  pc_next = jmp_tgt;
      OP_JZ:   pc_next = z_flag ? jmp_tgt : pc_inc;
      OP_JC:   pc_next = c_flag ? jmp_tgt : pc_inc;
      OP_HALT: pc_next = pc;
      default: pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      ALUResult <= '0;
      cpu_out   <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      instr_req <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            ir        <= instr_data;
            state     <= S_EXEC;
            instr_req <= 1'b0;
          end
        end
        S_EXEC: begin
          pc <= pc_next;
          if (alu_we) begin
            rf[rd]    <= alu_res;
            z_flag    <= (alu_res == '0);
            c_flag    <= alu_c;
            ALUResult <= alu_res;
          end else if (op == OP_LDI) begin
            rf[rd] <= imm_ext;
          end else if (op == OP_MOV) begin
            rf[rd] <= rs_val;
          end
          if (op == OP_OUT) begin
            cpu_out   <= rd_val;
            out_valid <= 1'b1;
          end
          if (op == OP_HALT) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            instr_req <= 1'b0;
          end else begin
            state     <= S_FETCH;
            instr_req <= 1'b1;
          end
        end
        S_HALT: begin
          halted    <= 1'b1;
          instr_req <= 1'b0;
        end
        default: begin
          state     <= S_FETCH;
          instr_req <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: a default instance (DATA_W=8, PC_W=8) driven by a
// programmable instruction memory with configurable wait states, and a
// DATA_W=16 / PC_W=4 instance for width and pc-wrap checks.
module tb_cpu_multicycle;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        req;
  logic [7:0]  addr;
  logic        valid;
  logic [15:0] data;
  logic [7:0]  alu;
  logic [7:0]  cout;
  logic        ov;
  logic        halted;
  logic [1:0]  st;
  logic [1:0]  fl;

  cpu_multicycle dut (
    .CLK(clk), .reset(rst_n), .instr_req(req), .instr_addr(addr),
    .instr_valid(valid), .instr_data(data), .ALUResult(alu), .cpu_out(cout),
    .out_valid(ov), .halted(halted), .dbg_state(st), .dbg_flags(fl)
  );

  logic        rst16 = 1'b0;
  logic        req16;
  logic [3:0]  addr16;
  logic        valid16;
  logic [15:0] data16;
  logic [15:0] alu16;
  logic [15:0] cout16;
  logic        ov16;
  logic        halted16;
  logic [1:0]  st16;
  logic [1:0]  fl16;

  cpu_multicycle #(.DATA_W(16), .PC_W(4)) dut16 (
    .CLK(clk), .reset(rst16), .instr_req(req16), .instr_addr(addr16),
    .instr_valid(valid16), .instr_data(data16), .ALUResult(alu16), .cpu_out(cout16),
    .out_valid(ov16), .halted(halted16), .dbg_state(st16), .dbg_flags(fl16)
  );

  // ---------------- bench state ----------------
  logic [15:0] mem [0:255];
  logic [15:0] mem16 [0:15];
  logic [15:0] prog [$];
  logic [3:0]  addr_log [$];
  logic [3:0]  exp_q [$];
  int          waits = 0;
  bit          force_valid = 1'b0;
  int          fetch_cnt = 0;
  int          out_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc;

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- instruction memory, 8-bit instance ----------------
  initial begin
    logic       prev_wait;
    logic [7:0] prev_addr;
    int         wcnt;
    prev_wait = 1'b0;
    prev_addr = '0;
    wcnt      = 0;
    valid     = 1'b0;
    data      = '0;
    forever begin
      @(negedge clk);
      if (ov) out_cnt++;
      if (rst_n && prev_wait && req) check("addr_stable", addr, prev_addr);
      if (force_valid) begin
        valid = 1'b1;
        data  = 16'h1005;
      end else if (req) begin
        if (wcnt >= waits) begin
          valid = 1'b1;
          data  = mem[addr];
        end else begin
          valid = 1'b0;
          data  = '0;
          wcnt++;
        end
      end else begin
        valid = 1'b0;
        wcnt  = 0;
      end
      if (rst_n && req && valid) begin
        fetch_cnt++;
        wcnt = 0;
      end
      if (!rst_n) wcnt = 0;
      prev_wait = rst_n && req && !valid;
      prev_addr = addr;
    end
  end

  // ---------------- instruction memory, 16-bit instance (zero wait) ----------------
  initial begin
    valid16 = 1'b0;
    data16  = '0;
    forever begin
      @(negedge clk);
      if (req16) begin
        valid16 = 1'b1;
        data16  = mem16[addr16];
      end else begin
        valid16 = 1'b0;
      end
      if (rst16 && req16 && valid16) addr_log.push_back(addr16);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_prog();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    foreach (prog[i]) mem[i] = prog[i];
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    fetch_cnt = 0;
    out_cnt   = 0;
  endtask

  // cyc = rising edges from reset release until halted is seen
  task automatic wait_halt(input int budget, output int c);
    c = 0;
    while (c < budget) begin
      @(negedge clk);
      if (halted) break;
      c++;
    end
    check("halt_reached", halted, 1);
  endtask

  task automatic run_prog(input int w, input int budget, output int c);
    waits = w;
    load_prog();
    assert_reset();
    release_reset();
    wait_halt(budget, c);
  endtask

  // Branch loop: fetches 0,1,(2,3,4)x2,2,3,5,6 -> 12 instructions.
  task automatic set_loop_prog();
    prog = {16'h1003, 16'h1401, 16'h3100, 16'hA005, 16'h9002, 16'h8000, 16'hF000};
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;

    // Reset with instr_valid held high for 2 edges
    force_valid = 1'b1;
    assert_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_alu", alu, 0);
    check("rst_cout", cout, 0);
    check("rst_ov", ov, 0);
    check("rst_halted", halted, 0);
    check("rst_req", req, 1);
    check("rst_addr", addr, 0);
    check("rst_state", st, 0);
    check("rst_flags", fl, 0);
    force_valid = 1'b0;

    // LDI r0,5; OUT r0; HALT : 3 instr -> 6 cycles
    prog = {16'h1005, 16'h8000, 16'hF000};
    waits = 0;
    load_prog();
    release_reset();
    wait_halt(100, cyc);
    check("p1_cout", cout, 5);
    check("p1_outcnt", out_cnt, 1);
    check("p1_req", req, 0);
    check("p1_state", st, 2);
    check("p1_pc_held", addr, 2);
    check("p1_cycles", cyc, 6);
    repeat (3) @(negedge clk);
    check("p1_still_halted", halted, 1);

    // 200+100=300 mod 256 = 44, C=1; LDI afterwards keeps flags
    prog = {16'h14C8, 16'h1864, 16'h2600, 16'h8400, 16'h1007, 16'hF000};
    run_prog(0, 100, cyc);
    check("add_alu", alu, 44);
    check("add_flags", fl, 2'b01);
    check("add_cout", cout, 44);
    check("add_cycles", cyc, 12);

    // ADD r1,r1 doubles 60 -> 120; SUB r2,r2 -> 0, Z=1 C=0
    prog = {16'h143C, 16'h2500, 16'h8400, 16'h1864, 16'h3A00, 16'hF000};
    run_prog(0, 100, cyc);
    check("dbl_cout", cout, 120);
    check("sub_alu", alu, 0);
    check("sub_flags", fl, 2'b10);

    // SHL 0x81 -> 0x02, C=1
    prog = {16'h1C81, 16'h7C00, 16'h8C00, 16'hF000};
    run_prog(0, 100, cyc);
    check("shl_alu", alu, 8'h02);
    check("shl_flags", fl, 2'b01);
    check("shl_cout", cout, 8'h02);

    // 0xFF+1 sets C; AND F0&3C=30 clears C; OR with 0 -> 30; XOR r0,r0 -> 0 Z=1
    prog = {16'h10F0, 16'h143C, 16'h18FF, 16'h1C01, 16'h2B00, 16'h4100,
            16'h5200, 16'h8000, 16'h6000, 16'hF000};
    run_prog(0, 100, cyc);
    check("logic_cout", cout, 8'h30);
    check("xor_alu", alu, 0);
    check("xor_flags", fl, 2'b10);

    // JC taken to 6: MOV r2,r1; OUT r2 -> 1. Fetches 0,1,2,3,6,7,8.
    prog = {16'h10FF, 16'h1401, 16'h2100, 16'hB006, 16'h8000, 16'hF000,
            16'hC900, 16'h8800, 16'hF000};
    run_prog(0, 100, cyc);
    check("jc_cout", cout, 1);
    check("jc_outcnt", out_cnt, 1);
    check("jc_halt_addr", addr, 8);
    check("jc_cycles", cyc, 14);

    // Branch loop, zero wait
    set_loop_prog();
    run_prog(0, 200, cyc);
    check("loop_cout", cout, 0);
    check("loop_outcnt", out_cnt, 1);
    check("loop_fetches", fetch_cnt, 12);
    check("loop_cycles", cyc, 24);

    // Branch loop, 3 wait states per fetch -> 5 cycles per instruction
    set_loop_prog();
    run_prog(3, 400, cyc);
    check("wait_cout", cout, 0);
    check("wait_outcnt", out_cnt, 1);
    check("wait_fetches", fetch_cnt, 12);
    check("wait_cycles", cyc, 60);

    // Opcode D: 16*17 = 0x110
    prog = {16'h1010, 16'h1411, 16'hD100, 16'h8000, 16'hF000};
    run_prog(0, 100, cyc);
    check("opd_cout", cout, 8'h10);
`ifdef HW_MUL_EN
    check("mul_alu", alu, 8'h10);
    check("mul_flags", fl, 2'b01);
`else
    check("opd_alu", alu, 0);
    check("opd_flags", fl, 2'b00);
`endif

    // Reset during a fetch wait, with r1=9, r2=7 loaded
    prog = {16'h1409, 16'h1807, 16'hF000};
    waits = 6;
    load_prog();
    assert_reset();
    release_reset();
    k = 0;
    while (fetch_cnt < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("mid_fetches", fetch_cnt, 2);
    repeat (4) @(negedge clk);
    check("mid_wait_addr", addr, 2);
    check("mid_wait_req", req, 1);
    assert_reset();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_addr", addr, 0);
    check("mid_rst_state", st, 0);
    // ADD r1,r2 on cleared registers -> 0, Z=1
    prog = {16'h2600, 16'h8400, 16'hF000};
    waits = 0;
    load_prog();
    release_reset();
    wait_halt(100, cyc);
    check("mid_regs_alu", alu, 0);
    check("mid_regs_flags", fl, 2'b10);
    check("mid_regs_outcnt", out_cnt, 1);

    // Reset during HALT
    prog = {16'h1409, 16'h1807, 16'hF000};
    run_prog(0, 100, cyc);
    check("hlt_req", req, 0);
    assert_reset();
    @(posedge clk);
    @(negedge clk);
    check("hlt_rst_halted", halted, 0);
    check("hlt_rst_req", req, 1);
    check("hlt_rst_addr", addr, 0);
    prog = {16'h2600, 16'h8400, 16'hF000};
    load_prog();
    release_reset();
    wait_halt(100, cyc);
    check("hlt_regs_alu", alu, 0);
    check("hlt_regs_flags", fl, 2'b10);

    // DATA_W=16: 0-1 = 0xFFFF, then +1 = 0 with C=1, Z=1
    for (int i = 0; i < 16; i++) mem16[i] = 16'hF000;
    mem16[0] = 16'h1000;
    mem16[1] = 16'h1401;
    mem16[2] = 16'h3100;
    mem16[3] = 16'h2100;
    @(posedge clk);
    #1 rst16 = 1'b0;
    @(posedge clk);
    #1 rst16 = 1'b1;
    k = 0;
    while (!halted16 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("w16_halted", halted16, 1);
    check("w16_alu", alu16, 16'h0000);
    check("w16_flags", fl16, 2'b11);

    // PC_W=4: straight NOP program wraps 15 -> 0
    for (int i = 0; i < 16; i++) mem16[i] = 16'h0000;
    @(posedge clk);
    #1 rst16 = 1'b0;
    @(posedge clk);
    #1 rst16 = 1'b1;
    addr_log.delete();
    k = 0;
    while (addr_log.size() < 18 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("wrap_count", (addr_log.size() >= 18), 1);
    for (int i = 0; i < 18; i++) exp_q.push_back(4'(i % 16));
    while (exp_q.size() > 0 && addr_log.size() > 0)
      check("wrap_addr", addr_log.pop_front(), exp_q.pop_front());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
